dino_jump_ctrl: RTL and testbench

Per-frame physics controller for the player sprite. It owns the dinosaur's vertical position and velocity, launches a jump on a button press, and advances the trajectory once per VGA frame. It sits directly upstream of `VGAController`: its `x_coor`/`y_coor` drive that block's sprite-bounds inputs, and the controller's `screen_ready` (end-of-frame strobe) drives this block's `frame_tick`.

---
 rtl/dino_pkg.sv | 17 +
 rtl/edge_sync.sv | 43 ++++
 rtl/dino_jump_ctrl.sv | 130 +++++++++++++
 tb/tb_dino_jump_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and default constants for the dino sprite physics
package dino_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        LANDED = 2'd2
    } dino_state_t;

    localparam int unsigned DINO_X   = 240;
    localparam int unsigned GROUND_Y = 400;
    localparam int unsigned JUMP_V   = 12;
    localparam int unsigned GRAVITY  = 1;
    // Must match the bounds logic in VGAController.
    localparam int unsigned SPRITE_H = 60;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - optional N-flop synchronizer followed by a registered rising-edge pulse
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);

    logic sig;
    logic prev_q;
    logic pulse_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sig = d_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
                end
            end
            assign sig = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= sig;
            pulse_q <= sig & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - per-frame jump physics for the player sprite
module dino_jump_ctrl #(
    parameter int unsigned DINO_X   = dino_pkg::DINO_X,
    parameter int unsigned GROUND_Y = dino_pkg::GROUND_Y,
    parameter int unsigned JUMP_V   = dino_pkg::JUMP_V,
    parameter int unsigned GRAVITY  = dino_pkg::GRAVITY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        jump_btn,
    input  logic        freeze,
    output logic [31:0] x_coor,
    output logic [31:0] y_coor,
    output logic        airborne,
    output logic [7:0]  jump_count
);

    import dino_pkg::*;

    localparam logic [11:0] GROUND_Y12 = 12'(GROUND_Y);
    localparam logic [7:0]  LAUNCH_VY  = ~8'(JUMP_V) + 8'd1;
    localparam logic [7:0]  GRAVITY8   = 8'(GRAVITY);

    // The apex must leave room for the whole sprite above row 0.
    generate
        if (int'(GROUND_Y) - int'(JUMP_V * (JUMP_V + 1) / 2) < int'(SPRITE_H)) begin : g_bad_params
            $error("dino_jump_ctrl: jump apex would push the sprite above the screen");
        end
    endgenerate

    logic press;
    logic tick;

    edge_sync #(.SYNC_STAGES(2)) u_btn_edge (
        .clk_i   (clk),
        .rst_ni  (reset),
        .d_i     (jump_btn),
        .pulse_o (press)
    );

    edge_sync #(.SYNC_STAGES(0)) u_frame_edge (
        .clk_i   (clk),
        .rst_ni  (reset),
        .d_i     (frame_tick),
        .pulse_o (tick)
    );

    dino_state_t state_q, state_d;
    logic [11:0] y_q, y_d;
    logic [7:0]  vy_q, vy_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pending_q, pending_d;

    logic               step;
    logic               launch;
    logic signed [12:0] ny;
    logic               touchdown;

    assign step      = tick & ~freeze;
    assign launch    = (state_q == GROUND) & step & (pending_q | press);
    assign ny        = $signed({1'b0, y_q}) + $signed({{5{vy_q[7]}}, vy_q});
    assign touchdown = ~vy_q[7] && (vy_q != 8'd0) && (ny >= $signed({1'b0, GROUND_Y12}));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= GROUND;
            y_q       <= GROUND_Y12;
            vy_q      <= 8'd0;
            cnt_q     <= 8'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            vy_q      <= vy_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GROUND:  if (launch) state_d = AIR;
            AIR:     if (step && touchdown) state_d = LANDED;
            LANDED:  if (step) state_d = GROUND;
            default: state_d = GROUND;
        endcase
    end

    always_comb begin
        y_d       = y_q;
        vy_d      = vy_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        unique case (state_q)
            GROUND: begin
                y_d  = GROUND_Y12;
                vy_d = 8'd0;
                if (launch) begin
                    vy_d      = LAUNCH_VY;
                    cnt_d     = cnt_q + 8'd1;
                    pending_d = 1'b0;
                end else if (press) begin
                    pending_d = 1'b1;
                end
            end
            AIR: begin
                if (step) begin
                    if (touchdown) begin
                        y_d  = GROUND_Y12;
                        vy_d = 8'd0;
                    end else begin
                        y_d  = ny[11:0];
                        vy_d = vy_q + GRAVITY8;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        airborne   = (state_q == AIR);
        x_coor     = 32'(DINO_X);
        y_coor     = {20'd0, y_q};
        jump_count = cnt_q;
    end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb/tb_dino_jump_ctrl.sv - directed self-checking bench for dino_jump_ctrl
module tb_dino_jump_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        jump_btn;
    logic        freeze;
    logic [31:0] x_coor;
    logic [31:0] y_coor;
    logic        airborne;
    logic [7:0]  jump_count;

    int checks = 0;
    int errors = 0;

    // y_coor after air ticks 1..27 of a jump launched from the ground
    int exp_y [27] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                       322, 323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388,
                       400, 400, 400};

    always #5 clk = ~clk;

    dino_jump_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .jump_btn   (jump_btn),
        .freeze     (freeze),
        .x_coor     (x_coor),
        .y_coor     (y_coor),
        .airborne   (airborne),
        .jump_count (jump_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic frame(input int hi, input int lo);
        @(negedge clk) frame_tick = 1'b1;
        repeat (hi) @(negedge clk);
        frame_tick = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic press_btn();
        @(negedge clk) jump_btn = 1'b1;
        repeat (5) @(negedge clk);
        jump_btn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        jump_btn   = 1'b0;
        freeze     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_y", y_coor, 400);
        chk("rst_x", x_coor, 240);
        chk("rst_air", 32'(airborne), 0);
        chk("rst_cnt", 32'(jump_count), 0);

        reset = 1'b1;
        repeat (10) frame(4, 3);
        chk("idle_y", y_coor, 400);
        chk("idle_air", 32'(airborne), 0);
        chk("idle_cnt", 32'(jump_count), 0);

        // Full jump with presses dropped in AIR (tick 5) and LANDED (tick 25)
        press_btn();
        frame(4, 3);
        chk("launch_y", y_coor, 400);
        chk("launch_air", 32'(airborne), 1);
        chk("launch_cnt", 32'(jump_count), 1);
        for (int t = 1; t <= 27; t++) begin
            frame(4, 3);
            chk($sformatf("jump_y_t%0d", t), y_coor, 32'(exp_y[t-1]));
            chk($sformatf("jump_air_t%0d", t), 32'(airborne), 32'(t <= 24));
            if (t == 5 || t == 25) press_btn();
        end
        chk("drop_cnt", 32'(jump_count), 1);

        press_btn();
        frame(4, 3);
        chk("relaunch_cnt", 32'(jump_count), 2);
        chk("relaunch_air", 32'(airborne), 1);

        // Freeze at the apex
        repeat (12) frame(4, 3);
        chk("apex_y", y_coor, 322);
        freeze = 1'b1;
        for (int k = 0; k < 5; k++) begin
            frame(4, 3);
            chk($sformatf("freeze_y_%0d", k), y_coor, 322);
        end
        chk("freeze_air", 32'(airborne), 1);
        freeze = 1'b0;
        for (int t = 13; t <= 20; t++) begin
            frame(4, 3);
            chk($sformatf("resume_y_t%0d", t), y_coor, 32'(exp_y[t-1]));
        end

        // Asynchronous reset mid-flight at y = 350, checked before the next clock edge
        #2 reset = 1'b0;
        #1;
        chk("async_rst_y", y_coor, 400);
        chk("async_rst_air", 32'(airborne), 0);
        chk("async_rst_cnt", 32'(jump_count), 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        // press and tick pulses land on the same clock edge
        jump_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (4) @(negedge clk);
        frame_tick = 1'b0;
        jump_btn   = 1'b0;
        repeat (3) @(negedge clk);
        chk("simul_cnt", 32'(jump_count), 1);
        chk("simul_air", 32'(airborne), 1);
        repeat (26) frame(2, 2);
        chk("simul_land_y", y_coor, 400);
        chk("simul_land_air", 32'(airborne), 0);

        // Counter wrap
        for (int i = 0; i < 254; i++) begin
            press_btn();
            repeat (27) frame(2, 2);
        end
        chk("cnt_255", 32'(jump_count), 255);
        press_btn();
        repeat (27) frame(2, 2);
        chk("cnt_wrap", 32'(jump_count), 0);
        chk("wrap_y", y_coor, 400);
        chk("wrap_air", 32'(airborne), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
